maxpool_relu_stream: RTL and testbench
======================================

Name: maxpool_relu_stream

Overview:
Parametrised successor to the fixed 24x24, 3-channel 2x2 max-pool+ReLU stage. It takes a raster-scan stream of NUM_CH-channel conv results and performs POOLxPOOL, stride-POOL max pooling with run-time selectable ReLU. It uses valid/ready handshakes on both sides. It sits between the conv engine and the next layer's input buffer, and it stores only one partial-max row of IN_W/POOL entries.

Parameters:
NUM_CH, 3, channels processed in parallel
DATA_W, 12, signed sample width per channel
IN_W, 24, input frame width (pixels)
IN_H, 24, input frame height (rows)
POOL, 2, window size and stride (2..4)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
relu_en  in  1  1: clamp negatives to 0; 0: pass signed max; sampled per output
in_valid  in  1  input sample valid
in_ready  out  1  block can accept input this cycle
in_sof  in  1  marks first pixel of a frame; qualified by in_valid&in_ready
in_data  in  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W], signed
out_valid  out  1  pooled result valid
out_ready  in  1  downstream accepts
out_data  out  NUM_CH*DATA_W  pooled result, same packing
out_last  out  1  with out_valid: last pooled pixel of the frame
busy  out  1  frame in progress (between accepted sof and accepted last input)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_last=0, busy=0, all counters=0, partial-row buffer contents don't-care (validity is tracked by counters). in_ready=1 after reset.
- Output size: OUT_W=floor(IN_W/POOL), OUT_H=floor(IN_H/POOL). Trailing columns and rows beyond OUT_W*POOL or OUT_H*POOL are accepted and discarded.
- Counters: x (0..IN_W-1) and y (0..IN_H-1), plus derived px=x mod POOL, py=y mod POOL, ox=x/POOL. All advance only on an accepted beat (in_valid&in_ready). Wrap: x wraps at IN_W-1 and y increments; after (IN_W-1, IN_H-1) both return to 0 and busy drops.
- in_sof: on an accepted beat, forces that beat to x=0,y=0 regardless of counter state. A mid-frame sof abandons the old frame with no output for the partial window, and busy=1. A beat at x=0,y=0 without sof is still processed; sof is for resync only.
- Horizontal stage: a register hmax per channel. At px==0 it loads the sample, otherwise hmax=max(hmax, sample), as a signed compare.
- Vertical stage: rowbuf[ox] per channel, depth OUT_W. At px==POOL-1 the window column set is complete, giving h=max(hmax, sample):
  - py==0: rowbuf[ox] <= h
  - 0<py<POOL-1: rowbuf[ox] <= max(rowbuf[ox], h)
  - py==POOL-1: result=max(rowbuf[ox], h), emitted.
- Emit: the result is registered into out_data on the clock edge that accepts the final window pixel, so out_valid rises the next cycle (latency 1). ReLU is applied at the register: negative values go to 0 if relu_en. out_last=1 when ox==OUT_W-1 and y/POOL==OUT_H-1.
- Backpressure: in_ready = !out_valid | out_ready, with the 1-entry output register. The output holds stable while out_valid & !out_ready. out_valid clears on acceptance unless a new result loads the same cycle, which keeps out_valid=1 with no bubble.
- Signed max ties keep either value (equal). Most-negative input is handled correctly and no arithmetic overflow is possible, since only compares are made.
- Reset mid-frame: all state clears immediately and any pending output is lost.

Decomposition:
- Shared package: DATA_W/NUM_CH defaults, signed-max function, ReLU function, channel pack/unpack macros; shared with conv and FC stages.
- One sub-module, pool_row_buffer: OUT_W x (NUM_CH*DATA_W) storage with 1 read and 1 write port, read address ox combinational. It is a flop array below 64 entries and RAM-inferable above.

Test Plan:
- IN_W=IN_H=4, NUM_CH=2, POOL=2, relu_en=1, ch0 = x+4y-8, ch1 = -(x+4y) -> 4 outputs with ch0 = {0,0,5,7} and ch1 = {0,0,0,0}; out_last only on the 4th output; latency 1 cycle after the beat at (1,1).
- Same frame with relu_en=0 -> ch0 = {-3,-1,5,7}, ch1 = {0,-2,-8,-10}.
- IN_W=5, IN_H=5, POOL=2 -> exactly 4 outputs; column 4 and row 4 are ignored; busy drops after the 25th beat.
- out_ready held 0 for 10 cycles during a frame -> in_ready=0 while out_valid is held, out_data stays stable, and no results are dropped or duplicated; totals match the golden model.
- in_sof asserted at (2,1) of frame A, then a full frame B -> no output for the partial window of A; frame B outputs are bit-exact.
- rst pulsed asynchronously mid-frame with in_valid held 1 -> outputs go 0 immediately; the next sof frame is correct.
- POOL=3, IN_W=IN_H=6, random data, back-to-back frames with random out_ready -> bit-exact against the reference model.

Source files
------------

// File: rtl/maxpool_relu_stream_pkg.sv
// Shared definitions for the CNN streaming stages: default widths and the
// signed compare / ReLU helpers, evaluated at a common wide width.
package maxpool_relu_stream_pkg;

    localparam int DEF_NUM_CH = 3;
    localparam int DEF_DATA_W = 12;
    localparam int MAX_W      = 32;

    typedef logic signed [MAX_W-1:0] wide_t;

    function automatic wide_t smax(input wide_t a, input wide_t b);
        return (a >= b) ? a : b;
    endfunction

    function automatic wide_t relu(input wide_t a, input logic en);
        return (en && a[MAX_W-1]) ? wide_t'(0) : a;
    endfunction

endpackage

// File: rtl/maxpool_relu_stream_pool_row_buffer.sv
// One row of partial vertical maxima, one entry per pooled output column.
// Read is combinational so the window max can be formed in the accepting cycle.
module pool_row_buffer #(
    parameter int DEPTH = 12,
    parameter int WIDTH = 36,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage write; contents are qualified by the frame counters, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/maxpool_relu_stream.sv
// POOLxPOOL stride-POOL max pooling with optional ReLU over a raster-scan
// multi-channel stream, keeping a single row of partial maxima.
module maxpool_relu_stream
    import maxpool_relu_stream_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IN_W   = 24,
    parameter int IN_H   = 24,
    parameter int POOL   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     relu_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sof,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     busy
);

    localparam int OUT_W = IN_W / POOL;
    localparam int OUT_H = IN_H / POOL;
    localparam int XW    = $clog2(IN_W);
    localparam int YW    = $clog2(IN_H);
    localparam int PW    = $clog2(POOL);
    localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int VW    = NUM_CH * DATA_W;

    logic [XW-1:0] x_q, x_d, x_s, ox_q, ox_d, ox_s;
    logic [YW-1:0] y_q, y_d, y_s, oy_q, oy_d, oy_s;
    logic [PW-1:0] px_q, px_d, px_s, py_q, py_d, py_s;
    logic          busy_q, busy_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [VW-1:0] hmax_q, hmax_d, out_data_q, out_data_d, res_s, rb_rdata_s, rb_wdata_s;
    logic [AW-1:0] rb_addr_s;
    logic          acc_s, px_last_s, py_last_s, col_ok_s, row_ok_s, frame_end_s, emit_s, rb_we_s;
    wide_t         samp_s, h_s, m_s;

    function automatic wide_t sext(input logic [DATA_W-1:0] v);
        return wide_t'({{(MAX_W-DATA_W){v[DATA_W-1]}}, v});
    endfunction

    assign in_ready = !out_valid_q | out_ready;
    assign acc_s    = in_valid & in_ready;

    // An accepted sof beat is treated as (0,0) whatever the counters say.
    assign x_s  = in_sof ? '0 : x_q;
    assign y_s  = in_sof ? '0 : y_q;
    assign px_s = in_sof ? '0 : px_q;
    assign py_s = in_sof ? '0 : py_q;
    assign ox_s = in_sof ? '0 : ox_q;
    assign oy_s = in_sof ? '0 : oy_q;

    assign px_last_s   = (px_s == PW'(POOL - 1));
    assign py_last_s   = (py_s == PW'(POOL - 1));
    assign col_ok_s    = (ox_s < XW'(OUT_W));
    assign row_ok_s    = (oy_s < YW'(OUT_H));
    assign frame_end_s = (x_s == XW'(IN_W - 1)) && (y_s == YW'(IN_H - 1));
    assign rb_addr_s   = col_ok_s ? ox_s[AW-1:0] : '0;
    assign rb_we_s     = acc_s & px_last_s & col_ok_s & row_ok_s & !py_last_s;
    assign emit_s      = acc_s & px_last_s & col_ok_s & row_ok_s & py_last_s;

    pool_row_buffer #(
        .DEPTH (OUT_W),
        .WIDTH (VW),
        .AW    (AW)
    ) u_row_buf (
        .clk   (clk),
        .we    (rb_we_s),
        .waddr (rb_addr_s),
        .wdata (rb_wdata_s),
        .raddr (rb_addr_s),
        .rdata (rb_rdata_s)
    );

    // Raster position counters and frame-in-progress flag.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        px_d   = px_q;
        py_d   = py_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        busy_d = busy_q;
        if (acc_s) begin
            busy_d = !frame_end_s;
            if (x_s == XW'(IN_W - 1)) begin
                x_d  = '0;
                px_d = '0;
                ox_d = '0;
                if (y_s == YW'(IN_H - 1)) begin
                    y_d  = '0;
                    py_d = '0;
                    oy_d = '0;
                end else if (py_last_s) begin
                    y_d  = y_s + YW'(1);
                    py_d = '0;
                    oy_d = oy_s + YW'(1);
                end else begin
                    y_d  = y_s + YW'(1);
                    py_d = py_s + PW'(1);
                    oy_d = oy_s;
                end
            end else begin
                x_d  = x_s + XW'(1);
                y_d  = y_s;
                py_d = py_s;
                oy_d = oy_s;
                if (px_last_s) begin
                    px_d = '0;
                    ox_d = ox_s + XW'(1);
                end else begin
                    px_d = px_s + PW'(1);
                    ox_d = ox_s;
                end
            end
        end else begin
            busy_d = busy_q;
        end
    end

    // Per-channel horizontal max, vertical merge with the row buffer, and ReLU.
    always_comb begin
        hmax_d     = hmax_q;
        rb_wdata_s = '0;
        res_s      = '0;
        samp_s     = '0;
        h_s        = '0;
        m_s        = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            samp_s = sext(in_data[c*DATA_W +: DATA_W]);
            h_s    = (px_s == '0) ? samp_s : smax(sext(hmax_q[c*DATA_W +: DATA_W]), samp_s);
            m_s    = smax(sext(rb_rdata_s[c*DATA_W +: DATA_W]), h_s);
            if (acc_s) begin
                hmax_d[c*DATA_W +: DATA_W] = DATA_W'(h_s);
            end else begin
                hmax_d[c*DATA_W +: DATA_W] = hmax_q[c*DATA_W +: DATA_W];
            end
            rb_wdata_s[c*DATA_W +: DATA_W] = (py_s == '0) ? DATA_W'(h_s) : DATA_W'(m_s);
            res_s[c*DATA_W +: DATA_W]      = DATA_W'(relu(m_s, relu_en));
        end
    end

    // One-entry output register; a new result may replace an accepted one with no bubble.
    always_comb begin
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        if (emit_s) begin
            out_valid_d = 1'b1;
            out_data_d  = res_s;
            out_last_d  = (ox_s == XW'(OUT_W - 1)) && (oy_s == YW'(OUT_H - 1));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            px_q        <= '0;
            py_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            busy_q      <= 1'b0;
            hmax_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            px_q        <= px_d;
            py_q        <= py_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            busy_q      <= busy_d;
            hmax_q      <= hmax_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_maxpool_relu_stream.sv
// Scoreboard bench: three pooling configurations share one driver and one
// monitor; expectations come from constant tables or a full-window model.
module tb_maxpool_relu_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        relu_en = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [23:0] in_data = 24'd0;
    logic        out_ready = 1'b1;
    int          sel = 0;
    int          rdy_mode = 0;

    logic        in_ready_a, out_valid_a, out_last_a, busy_a;
    logic        in_ready_b, out_valid_b, out_last_b, busy_b;
    logic        in_ready_c, out_valid_c, out_last_c, busy_c;
    logic [23:0] out_data_a, out_data_b, out_data_c;
    logic        in_ready_m, out_valid_m, out_last_m, busy_m;
    logic [23:0] out_data_m;

    int          n_checks = 0;
    int          n_errors = 0;
    int          out_cnt = 0;
    int          hold_n = 0;
    logic        hold_v = 1'b0;
    logic [23:0] hold_d = 24'd0;
    logic [24:0] exp_q [$];
    int          pix0 [64];
    int          pix1 [64];

    always #5 clk = ~clk;

    maxpool_relu_stream #(.NUM_CH(2), .DATA_W(12), .IN_W(4), .IN_H(4), .POOL(2)) dut_a (
        .clk(clk), .rst(rst), .relu_en(relu_en), .in_valid(in_valid && sel == 0),
        .in_ready(in_ready_a), .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_last(out_last_a), .busy(busy_a));

    maxpool_relu_stream #(.NUM_CH(2), .DATA_W(12), .IN_W(5), .IN_H(5), .POOL(2)) dut_b (
        .clk(clk), .rst(rst), .relu_en(relu_en), .in_valid(in_valid && sel == 1),
        .in_ready(in_ready_b), .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_last(out_last_b), .busy(busy_b));

    maxpool_relu_stream #(.NUM_CH(2), .DATA_W(12), .IN_W(6), .IN_H(6), .POOL(3)) dut_c (
        .clk(clk), .rst(rst), .relu_en(relu_en), .in_valid(in_valid && sel == 2),
        .in_ready(in_ready_c), .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid_c),
        .out_ready(out_ready), .out_data(out_data_c), .out_last(out_last_c), .busy(busy_c));

    always_comb begin
        case (sel)
            0:       begin in_ready_m = in_ready_a; out_valid_m = out_valid_a; out_data_m = out_data_a; out_last_m = out_last_a; busy_m = busy_a; end
            1:       begin in_ready_m = in_ready_b; out_valid_m = out_valid_b; out_data_m = out_data_b; out_last_m = out_last_b; busy_m = busy_b; end
            default: begin in_ready_m = in_ready_c; out_valid_m = out_valid_c; out_data_m = out_data_c; out_last_m = out_last_c; busy_m = busy_c; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input int c0, input int c1, input bit last);
        logic [11:0] a, b;
        a = c0[11:0];
        b = c1[11:0];
        exp_q.push_back({last, b, a});
    endtask

    task automatic fill(input int kind, input int w, input int h);
        for (int i = 0; i < w * h; i++) begin
            if (kind == 0) begin
                pix0[i] = (i % w) + 4 * (i / w) - 8;
                pix1[i] = -((i % w) + 4 * (i / w));
            end else begin
                pix0[i] = ($urandom_range(0, 7) == 0) ? -2048 : int'($urandom_range(0, 4095)) - 2048;
                pix1[i] = ($urandom_range(0, 7) == 0) ? 2047 : int'($urandom_range(0, 4095)) - 2048;
            end
        end
    endtask

    // Reference: full-window max for every window whose last pixel is among the first n beats.
    task automatic model(input int w, input int h, input int p, input int n, input bit relu);
        int ow, oh, li, idx, m0, m1;
        ow = w / p;
        oh = h / p;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                li = (oy * p + p - 1) * w + ox * p + p - 1;
                if (li < n) begin
                    m0 = -100000;
                    m1 = -100000;
                    for (int dy = 0; dy < p; dy++) begin
                        for (int dx = 0; dx < p; dx++) begin
                            idx = (oy * p + dy) * w + ox * p + dx;
                            if (pix0[idx] > m0) m0 = pix0[idx];
                            if (pix1[idx] > m1) m1 = pix1[idx];
                        end
                    end
                    if (relu && m0 < 0) m0 = 0;
                    if (relu && m1 < 0) m1 = 0;
                    push_exp(m0, m1, (ox == ow - 1) && (oy == oh - 1));
                end
            end
        end
    endtask

    // Called at posedge+1; leaves in_valid high and returns at posedge+1 after acceptance.
    task automatic drive_beat(input logic sof, input int i);
        int   t;
        logic acc;
        logic [11:0] a, b;
        a = pix0[i][11:0];
        b = pix1[i][11:0];
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = {b, a};
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready_m;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) check("beat_timeout", 32'd0, 32'd1);
        in_sof = 1'b0;
    endtask

    task automatic drive_frame(input int n, input int lat_idx);
        for (int i = 0; i < n; i++) begin
            if (i == lat_idx) check("pre_latency_valid", {31'd0, out_valid_m}, 32'd0);
            drive_beat(i == 0, i);
            if (i == lat_idx) begin
                in_valid = 1'b0;
                @(negedge clk);
                check("latency_valid", {31'd0, out_valid_m}, 32'd1);
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Output monitor: hold stability under backpressure and scoreboard pop on acceptance.
    always @(negedge clk) begin
        logic [24:0] e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && out_valid_m) check("hold_data", out_data_m, hold_d);
            if (out_valid_m && !out_ready) begin
                check("in_ready_hold", {31'd0, in_ready_m}, 32'd0);
                hold_v = 1'b1;
                hold_d = out_data_m;
                hold_n++;
            end else begin
                hold_v = 1'b0;
            end
            if (out_valid_m && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {8'd0, out_data_m}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {8'd0, out_data_m}, {8'd0, e[23:0]});
                    check("out_last", {31'd0, out_last_m}, {31'd0, e[24]});
                end
            end
        end
    end

    initial begin
        int o, t;
        repeat (3) @(posedge clk);
        check("rst_out_valid", {31'd0, out_valid_m}, 32'd0);
        check("rst_out_data", {8'd0, out_data_m}, 32'd0);
        check("rst_busy", {31'd0, busy_m}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready_m}, 32'd1);
        check("rst_out_last", {31'd0, out_last_m}, 32'd0);
        @(posedge clk);
        #1;

        // 4x4 ramp frame, ReLU on then off, against hand-derived values.
        sel = 0;
        relu_en = 1'b1;
        fill(0, 4, 4);
        push_exp(0, 0, 0); push_exp(0, 0, 0); push_exp(5, 0, 0); push_exp(7, 0, 1);
        drive_frame(16, 5);
        drain();
        relu_en = 1'b0;
        push_exp(-3, 0, 0); push_exp(-1, -2, 0); push_exp(5, -8, 0); push_exp(7, -10, 1);
        drive_frame(16, -1);
        drain();

        // 5x5: trailing column and row discarded, busy drops after the 25th beat.
        sel = 1;
        fill(1, 5, 5);
        model(5, 5, 2, 25, 1'b0);
        o = out_cnt;
        drive_frame(25, -1);
        check("busy_after_frame", {31'd0, busy_m}, 32'd0);
        drain();
        check("odd_out_count", out_cnt - o, 32'd4);

        // Backpressure: out_ready low for 10 cycles once a result is pending.
        relu_en = 1'b1;
        fill(1, 5, 5);
        model(5, 5, 2, 25, 1'b1);
        hold_n = 0;
        rdy_mode = 2;
        fork
            drive_frame(25, -1);
            begin
                t = 0;
                while (!out_valid_m && t < 300) begin @(posedge clk); t++; end
                repeat (10) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();
        check("hold_seen", {31'd0, hold_n >= 5}, 32'd1);

        // Mid-frame sof resync: frame A cut at (2,1), then a full frame B.
        relu_en = 1'b0;
        fill(1, 5, 5);
        model(5, 5, 2, 7, 1'b0);
        drive_frame(7, -1);
        check("busy_mid_frame", {31'd0, busy_m}, 32'd1);
        fill(1, 5, 5);
        model(5, 5, 2, 25, 1'b0);
        drive_frame(25, -1);
        check("busy_after_b", {31'd0, busy_m}, 32'd0);
        drain();

        // Asynchronous reset with a result pending and in_valid held high.
        rdy_mode = 2;
        fill(1, 5, 5);
        for (int i = 0; i < 7; i++) drive_beat(i == 0, i);
        check("pre_rst_valid", {31'd0, out_valid_m}, 32'd1);
        check("pre_rst_busy", {31'd0, busy_m}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid_m}, 32'd0);
        check("async_rst_data", {8'd0, out_data_m}, 32'd0);
        check("async_rst_busy", {31'd0, busy_m}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;
        rdy_mode = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        fill(1, 5, 5);
        model(5, 5, 2, 25, 1'b0);
        drive_frame(25, -1);
        drain();

        // POOL=3 on 6x6, back-to-back random frames with random out_ready.
        sel = 2;
        rdy_mode = 1;
        for (int f = 0; f < 4; f++) begin
            relu_en = 1'($urandom_range(0, 1));
            fill(1, 6, 6);
            model(6, 6, 3, 36, relu_en);
            drive_frame(36, -1);
        end
        drain();
        rdy_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
